// File: rtl/monkey_anim_ctrl.sv
// Frame-synchronous animation sequencer: eye blink FSM, arm wave and frame counter.
// All state advances only on frame_start so the colour datapath never sees a mid-frame change.
module monkey_anim_ctrl #(
    parameter int BLINK_PERIOD   = 120,
    parameter int BLINK_FRAMES   = 6,
    parameter int REFRACT_FRAMES = 2,
    parameter int ARM_MAX        = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       cfg_pause,
    input  logic [1:0] cfg_speed,
    input  logic       blink_req,
    output logic       blink,
    output logic       wave_phase,
    output logic [5:0] arm_offset,
    output logic [7:0] frame_cnt,
    output logic       blink_pending
);

    typedef enum logic [1:0] {
        ST_OPEN    = 2'd0,
        ST_CLOSED  = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    localparam logic [7:0] OPEN_LAST    = 8'(BLINK_PERIOD - 1);
    localparam logic [7:0] CLOSED_LAST  = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] REFRACT_LAST = 8'(REFRACT_FRAMES - 1);
    localparam logic [6:0] ARM_MAX7     = 7'(ARM_MAX);
    localparam logic [5:0] ARM_MAX6     = 6'(ARM_MAX);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       blink_q, blink_d;
    logic       phase_q, phase_d;
    logic [5:0] arm_q, arm_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       pending_q, pending_d;

    logic       advance;
    logic       enter_closed;
    logic [5:0] step;
    logic [6:0] arm_sum;

    assign advance = frame_start && !cfg_pause;
    assign step    = {4'b0, cfg_speed} + 6'd1;
    assign arm_sum = {1'b0, arm_q} + {1'b0, step};

    // A request coincident with the OPEN->CLOSED edge is consumed by it.
    assign enter_closed = advance && (state_q == ST_OPEN) &&
                          (pending_q || blink_req || timer_q == OPEN_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        phase_d     = phase_q;
        arm_d       = arm_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
        pending_d   = enter_closed ? 1'b0 : (blink_req ? 1'b1 : pending_q);

        if (advance) begin
            case (state_q)
                ST_OPEN: begin
                    if (enter_closed) begin
                        state_d = ST_CLOSED;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ST_CLOSED: begin
                    if (timer_q == CLOSED_LAST) begin
                        state_d = ST_REFRACT;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                ST_REFRACT: begin
                    if (timer_q == REFRACT_LAST) begin
                        state_d = ST_OPEN;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_OPEN;
                    timer_d = 8'd0;
                end
            endcase

            // Saturate at both ends so the offset never wraps.
            if (!phase_q) begin
                if (arm_sum >= ARM_MAX7) begin
                    arm_d   = ARM_MAX6;
                    phase_d = 1'b1;
                end else begin
                    arm_d = arm_sum[5:0];
                end
            end else begin
                if (arm_q <= step) begin
                    arm_d   = 6'd0;
                    phase_d = 1'b0;
                end else begin
                    arm_d = arm_q - step;
                end
            end
        end

        blink_d = (state_d == ST_CLOSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OPEN;
            timer_q     <= 8'd0;
            blink_q     <= 1'b0;
            phase_q     <= 1'b0;
            arm_q       <= 6'd0;
            frame_cnt_q <= 8'd0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            arm_q       <= arm_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
        end
    end

    assign blink         = blink_q;
    assign wave_phase    = phase_q;
    assign arm_offset    = arm_q;
    assign frame_cnt     = frame_cnt_q;
    assign blink_pending = pending_q;

endmodule

// File: tb/tb_monkey_anim_ctrl.sv
// Directed bench for monkey_anim_ctrl with default parameters (120/6/2/30).
module tb_monkey_anim_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       cfg_pause;
    logic [1:0] cfg_speed;
    logic       blink_req;
    logic       blink;
    logic       wave_phase;
    logic [5:0] arm_offset;
    logic [7:0] frame_cnt;
    logic       blink_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    monkey_anim_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .cfg_pause    (cfg_pause),
        .cfg_speed    (cfg_speed),
        .blink_req    (blink_req),
        .blink        (blink),
        .wave_phase   (wave_phase),
        .arm_offset   (arm_offset),
        .frame_cnt    (frame_cnt),
        .blink_pending(blink_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_start = 1'b1;
            @(negedge clk) frame_start = 1'b0;
        end
    endtask

    task automatic req_pulse();
        @(negedge clk) blink_req = 1'b1;
        @(negedge clk) blink_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; cfg_pause = 1'b0; cfg_speed = 2'd3; blink_req = 1'b0;
        #12;
        chk("rst_blink", blink, 0);
        chk("rst_phase", wave_phase, 0);
        chk("rst_arm", arm_offset, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_pend", blink_pending, 0);
        @(negedge clk) rst_n = 1'b1;

        // speed 3: 4,8,..,28 then 30 falling
        frames(7);
        chk("s3_arm7", arm_offset, 28);
        chk("s3_ph7", wave_phase, 0);
        frames(1);
        chk("s3_arm8", arm_offset, 30);
        chk("s3_ph8", wave_phase, 1);
        frames(1);
        chk("s3_arm9", arm_offset, 26);
        frames(6);
        chk("s3_arm15", arm_offset, 2);
        frames(1);
        chk("s3_arm16", arm_offset, 0);
        chk("s3_ph16", wave_phase, 0);

        // automatic blink at frame 120
        frames(103);
        chk("auto_blink119", blink, 0);
        frames(1);
        chk("auto_blink120", blink, 1);
        chk("arm120", arm_offset, 30);
        repeat (5) @(negedge clk);
        chk("stable_blink", blink, 1);
        chk("stable_fcnt", frame_cnt, 120);
        frames(5);
        chk("blink125", blink, 1);
        frames(1);
        chk("blink126", blink, 0);
        chk("fcnt126", frame_cnt, 126);

        // request in REFRACT waits until OPEN
        req_pulse();
        chk("refr_pend", blink_pending, 1);
        frames(2);
        chk("refr_blink128", blink, 0);
        chk("refr_pend128", blink_pending, 1);
        frames(1);
        chk("refr_blink129", blink, 1);
        chk("refr_pend129", blink_pending, 0);

        // request in CLOSED held through CLOSED and REFRACT
        req_pulse();
        chk("cl_pend", blink_pending, 1);
        frames(6);
        chk("cl_blink135", blink, 0);
        chk("cl_pend135", blink_pending, 1);
        frames(2);
        chk("cl_blink137", blink, 0);
        frames(1);
        chk("cl_blink138", blink, 1);
        chk("cl_pend138", blink_pending, 0);
        chk("arm138", arm_offset, 22);

        // pause for 10 frames during CLOSED
        cfg_pause = 1'b1;
        frames(5);
        req_pulse();
        frames(5);
        chk("pz_blink", blink, 1);
        chk("pz_arm", arm_offset, 22);
        chk("pz_fcnt", frame_cnt, 148);
        chk("pz_pend", blink_pending, 1);
        cfg_pause = 1'b0;
        frames(1);
        chk("unpz_arm", arm_offset, 18);
        chk("unpz_blink", blink, 1);

        // async reset mid-frame with blink=1, pending=1
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("ar_blink", blink, 0);
        chk("ar_arm", arm_offset, 0);
        chk("ar_pend", blink_pending, 0);
        chk("ar_fcnt", frame_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        frames(1);
        chk("ar_arm1", arm_offset, 4);
        chk("ar_blink1", blink, 0);
        chk("ar_pend1", blink_pending, 0);

        // speed 0, manual request at OPEN timer=10
        cfg_speed = 2'd0;
        do_reset();
        frames(10);
        req_pulse();
        repeat (3) @(negedge clk);
        chk("man_pend", blink_pending, 1);
        chk("man_blink0", blink, 0);
        frames(1);
        chk("man_blink", blink, 1);
        chk("man_pend_clr", blink_pending, 0);
        frames(18);
        chk("s0_arm29", arm_offset, 29);
        chk("s0_ph29", wave_phase, 0);
        frames(1);
        chk("s0_arm30", arm_offset, 30);
        chk("s0_ph30", wave_phase, 1);
        frames(29);
        chk("s0_arm59", arm_offset, 1);
        frames(1);
        chk("s0_arm60", arm_offset, 0);
        chk("s0_ph60", wave_phase, 0);

        // request coincident with OPEN->CLOSED is consumed
        @(negedge clk) begin frame_start = 1'b1; blink_req = 1'b1; end
        @(negedge clk) begin frame_start = 1'b0; blink_req = 1'b0; end
        chk("coin_blink", blink, 1);
        chk("coin_pend", blink_pending, 0);

        // back-to-back frame_start cycles
        @(negedge clk) frame_start = 1'b1;
        repeat (3) @(negedge clk);
        frame_start = 1'b0;
        chk("b2b_fcnt", frame_cnt, 64);
        chk("b2b_arm", arm_offset, 4);
        chk("b2b_blink", blink, 1);

        // frame counter wrap
        do_reset();
        frames(255);
        chk("fcnt255", frame_cnt, 255);
        frames(1);
        chk("fcnt_wrap", frame_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
